old_bpm_sequencer: RTL and testbench

OLD_BPM_SEQUENCER -- requirements
Module: old_bpm_sequencer

---
 rtl/old_bpm_sequencer.sv | 135 +++++++++++++
 tb/tb_old_bpm_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/old_bpm_sequencer.sv
// Old BPM sequencer: turns one 96-bit record into four GPIO writes (index X, data X, index Y, data Y).
// Latency: first strobe one cycle after acceptance; one record per 4 cycles when back-to-back.
// Backpressure: recTREADY only in IDLE/DAT_Y, with enable set and fewer than FIFO_DEPTH pairs outstanding.
module old_bpm_sequencer #(
    parameter string DEBUG      = "false",
    parameter int    FIFO_DEPTH = 16
) (
    (* mark_debug = DEBUG *) input  logic        clk,
    (* mark_debug = DEBUG *) input  logic        reset,
    (* mark_debug = DEBUG *) input  logic        enable,
    (* mark_debug = DEBUG *) input  logic        recTVALID,
    (* mark_debug = DEBUG *) output logic        recTREADY,
    (* mark_debug = DEBUG *) input  logic [95:0] recTDATA,
    (* mark_debug = DEBUG *) output logic        indexStrobe,
    (* mark_debug = DEBUG *) output logic        dataStrobe,
    (* mark_debug = DEBUG *) output logic [31:0] gpioOut,
    (* mark_debug = DEBUG *) input  logic        fifoPop,
    (* mark_debug = DEBUG *) output logic [4:0]  outstanding,
    (* mark_debug = DEBUG *) output logic [15:0] recordCount,
    (* mark_debug = DEBUG *) output logic        underflow
);

    typedef enum logic [2:0] {
        IDLE,
        IDX_X,
        DAT_X,
        IDX_Y,
        DAT_Y
    } state_t;

    localparam logic [4:0] DEPTH_LIMIT = 5'(FIFO_DEPTH);

    state_t      state;
    state_t      state_next;
    logic [31:0] x_hi;
    logic [31:0] y_hi;
    logic [7:0]  x_lo;
    logic [7:0]  y_lo;
    logic [8:0]  bpm_index;
    logic [4:0]  out_cnt;
    logic [15:0] rec_cnt;
    logic        underflow_flag;
    logic        accept;
    logic        pop_valid;
    logic        unused_bits;

    // Reserved record bits and the DEBUG parameter have no effect on logic.
    assign unused_bits = ^{recTDATA[95:89], (DEBUG == "true")};

    // Compare uses the registered count, so a same-cycle pop cannot open the gate at full depth.
    assign recTREADY = ~reset & enable & ((state == IDLE) || (state == DAT_Y))
                     & (out_cnt < DEPTH_LIMIT);
    assign accept    = recTVALID & recTREADY;
    assign pop_valid = fifoPop & (out_cnt != 5'd0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? IDX_X : IDLE;
            IDX_X:   state_next = DAT_X;
            DAT_X:   state_next = IDX_Y;
            IDX_Y:   state_next = DAT_Y;
            DAT_Y:   state_next = accept ? IDX_X : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        indexStrobe = 1'b0;
        dataStrobe  = 1'b0;
        gpioOut     = 32'd0;
        case (state)
            IDX_X: begin
                indexStrobe = 1'b1;
                gpioOut     = {x_lo, 14'd0, 1'b0, bpm_index};
            end
            DAT_X: begin
                dataStrobe = 1'b1;
                gpioOut    = x_hi;
            end
            IDX_Y: begin
                indexStrobe = 1'b1;
                gpioOut     = {y_lo, 14'd0, 1'b1, bpm_index};
            end
            DAT_Y: begin
                dataStrobe = 1'b1;
                gpioOut    = y_hi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            x_hi      <= recTDATA[31:0];
            y_hi      <= recTDATA[63:32];
            x_lo      <= recTDATA[71:64];
            y_lo      <= recTDATA[79:72];
            bpm_index <= recTDATA[88:80];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt        <= 5'd0;
            rec_cnt        <= 16'd0;
            underflow_flag <= 1'b0;
        end else begin
            case ({accept, pop_valid})
                2'b10:   out_cnt <= out_cnt + 5'd1;
                2'b01:   out_cnt <= out_cnt - 5'd1;
                default: out_cnt <= out_cnt;
            endcase
            if (state == DAT_Y) begin
                rec_cnt <= rec_cnt + 16'd1;
            end
            if (fifoPop && (out_cnt == 5'd0)) begin
                underflow_flag <= 1'b1;
            end
        end
    end

    assign outstanding = out_cnt;
    assign recordCount = rec_cnt;
    assign underflow   = underflow_flag;

endmodule

// File: tb/tb_old_bpm_sequencer.sv
// Bench for old_bpm_sequencer: per-cycle comparison against a record-offset model plus directed literal checks.
module tb_old_bpm_sequencer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        recTVALID;
    logic        recTREADY;
    logic [95:0] recTDATA;
    logic        indexStrobe;
    logic        dataStrobe;
    logic [31:0] gpioOut;
    logic        fifoPop;
    logic [4:0]  outstanding;
    logic [15:0] recordCount;
    logic        underflow;

    old_bpm_sequencer #(.DEBUG("false"), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .recTVALID(recTVALID), .recTREADY(recTREADY), .recTDATA(recTDATA),
        .indexStrobe(indexStrobe), .dataStrobe(dataStrobe), .gpioOut(gpioOut),
        .fifoPop(fifoPop), .outstanding(outstanding),
        .recordCount(recordCount), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m_phase is the cycle offset since the current record was accepted (0 = nothing in flight).
    int          m_phase = 0;
    logic [31:0] m_xh, m_yh;
    logic [7:0]  m_xb, m_yb;
    logic [8:0]  m_idx;
    int          m_outs = 0;
    logic [15:0] m_cnt = 16'd0;
    bit          m_uf = 1'b0;
    int          cyc = 0;
    int          acc_total = 0;
    int          acc_cyc[$];

    function automatic bit m_ready();
        return !reset && enable && (m_phase == 0 || m_phase == 4) && (m_outs < DEPTH);
    endfunction

    function automatic bit m_acc();
        return recTVALID && m_ready();
    endfunction

    function automatic logic [31:0] exp_gpio();
        case (m_phase)
            1:       return (32'(m_xb) << 24) | 32'(m_idx);
            2:       return m_xh;
            3:       return (32'(m_yb) << 24) | 32'h200 | 32'(m_idx);
            4:       return m_yh;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_phase <= 0;
            m_outs  <= 0;
            m_cnt   <= 16'd0;
            m_uf    <= 1'b0;
        end else begin
            if (m_phase == 4) m_cnt <= m_cnt + 16'd1;
            if (m_acc()) begin
                m_phase   <= 1;
                m_xh      <= recTDATA[31:0];
                m_yh      <= recTDATA[63:32];
                m_xb      <= recTDATA[71:64];
                m_yb      <= recTDATA[79:72];
                m_idx     <= recTDATA[88:80];
                acc_total <= acc_total + 1;
                acc_cyc.push_back(cyc);
            end else if (m_phase == 0 || m_phase == 4) begin
                m_phase <= 0;
            end else begin
                m_phase <= m_phase + 1;
            end
            m_outs <= m_outs + (m_acc() ? 1 : 0) - ((fifoPop && m_outs > 0) ? 1 : 0);
            if (fifoPop && m_outs == 0) m_uf <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_recTREADY",   32'(recTREADY),   32'(m_ready()));
            chk("cyc_indexStrobe", 32'(indexStrobe), 32'(m_phase == 1 || m_phase == 3));
            chk("cyc_dataStrobe",  32'(dataStrobe),  32'(m_phase == 2 || m_phase == 4));
            chk("cyc_gpioOut",     gpioOut,          exp_gpio());
            chk("cyc_outstanding", 32'(outstanding), 32'(m_outs));
            chk("cyc_recordCount", 32'(recordCount), 32'(m_cnt));
            chk("cyc_underflow",   32'(underflow),   32'(m_uf));
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_n(input int n);
        fifoPop = 1'b1;
        cycles(n);
        fifoPop = 1'b0;
    endtask

    function automatic logic [95:0] mk_rec(input int i);
        return {7'h55, 9'(i * 37 + 1), 8'(i + 1), 8'(i * 3), 32'h40000000 + 32'(i), 32'hC0000000 - 32'(i)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_g [4];
        int base;
        bit ok;
        bit found;

        reset = 1'b1; enable = 1'b0; recTVALID = 1'b0; fifoPop = 1'b0; recTDATA = '0;
        cycles(1);
        check_en = 1'b1;
        enable = 1'b1;
        recTVALID = 1'b1;
        @(negedge clk);
        chk("ready_low_in_reset", 32'(recTREADY), 32'd0);
        recTVALID = 1'b0;
        cycles(1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_index", 32'(indexStrobe), 32'd0);
        chk("rst_data", 32'(dataStrobe), 32'd0);
        chk("rst_gpio", gpioOut, 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_count", 32'(recordCount), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("ready_after_rst", 32'(recTREADY), 32'd1);

        // Single record, hand-computed GPIO words.
        recTDATA = {7'h7F, 9'h1A5, 8'h34, 8'h12, 32'hBFF00000, 32'h3FF00000};
        recTVALID = 1'b1;
        cycles(1);
        recTVALID = 1'b0;
        exp_g = '{32'h120001A5, 32'h3FF00000, 32'h340003A5, 32'hBFF00000};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("single_gpio%0d", k), gpioOut, exp_g[k]);
            chk($sformatf("single_idx%0d", k), 32'(indexStrobe), 32'(k % 2 == 0));
        end
        @(negedge clk);
        chk("single_count", 32'(recordCount), 32'd1);
        chk("single_outstanding", 32'(outstanding), 32'd1);
        pop_n(1);
        @(negedge clk);
        chk("single_drained", 32'(outstanding), 32'd0);

        // Continuous valid with no pops: capacity limits acceptance to DEPTH records.
        acc_cyc.delete();
        base = acc_total;
        recTVALID = 1'b1;
        for (int i = 0; i < 90; i++) begin
            recTDATA = mk_rec(acc_total - base < 20 ? acc_total - base : 19);
            cycles(1);
        end
        @(negedge clk);
        chk("full_accepted", 32'(acc_total - base), 32'd16);
        ok = (acc_cyc.size() == 16);
        for (int j = 1; j < acc_cyc.size(); j++) begin
            if (acc_cyc[j] - acc_cyc[j-1] != 4) ok = 1'b0;
        end
        chk("full_spacing", 32'(ok), 32'd1);
        chk("full_outstanding", 32'(outstanding), 32'd16);
        chk("full_ready_low", 32'(recTREADY), 32'd0);
        pop_n(1);
        chk("pop_edge_no_accept", 32'(acc_total - base), 32'd16);
        @(negedge clk);
        chk("ready_after_pop", 32'(recTREADY), 32'd1);
        cycles(1);
        recTVALID = 1'b0;
        chk("accept_after_pop", 32'(acc_total - base), 32'd17);
        @(negedge clk);
        chk("refilled_outstanding", 32'(outstanding), 32'd16);
        cycles(4);
        pop_n(16);
        @(negedge clk);
        chk("full_drained", 32'(outstanding), 32'd0);

        // Pop coinciding with acceptance at outstanding = 5.
        found = 1'b0;
        recTVALID = 1'b1;
        recTDATA = mk_rec(3);
        for (int i = 0; i < 60 && !found; i++) begin
            cycles(1);
            if (m_outs == 5 && m_ready()) begin
                fifoPop = 1'b1;
                cycles(1);
                fifoPop = 1'b0;
                recTVALID = 1'b0;
                found = 1'b1;
            end
        end
        chk("pop_accept_reached", 32'(found), 32'd1);
        @(negedge clk);
        chk("pop_accept_outstanding", 32'(outstanding), 32'd5);
        cycles(5);
        pop_n(5);
        @(negedge clk);
        chk("five_drained", 32'(outstanding), 32'd0);

        // Underflow is sticky and leaves the count at zero.
        pop_n(1);
        @(negedge clk);
        chk("uf_outstanding", 32'(outstanding), 32'd0);
        chk("uf_set", 32'(underflow), 32'd1);

        // Enable dropped during DAT_X: the record still completes.
        recTVALID = 1'b1;
        recTDATA = mk_rec(7);
        cycles(2);
        enable = 1'b0;
        @(negedge clk);
        chk("en_dat_x", 32'(dataStrobe), 32'd1);
        @(negedge clk);
        chk("en_idx_y", 32'(indexStrobe), 32'd1);
        @(negedge clk);
        chk("en_dat_y", 32'(dataStrobe), 32'd1);
        chk("en_dat_y_ready", 32'(recTREADY), 32'd0);
        @(negedge clk);
        chk("en_idle_strobes", 32'({indexStrobe, dataStrobe}), 32'd0);
        chk("en_idle_ready", 32'(recTREADY), 32'd0);
        chk("uf_sticky", 32'(underflow), 32'd1);
        recTVALID = 1'b0;
        enable = 1'b1;
        pop_n(1);

        // Reset during IDX_Y cuts the record short.
        recTVALID = 1'b1;
        recTDATA = mk_rec(9);
        cycles(1);
        recTVALID = 1'b0;
        cycles(2);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_idx_y", 32'(indexStrobe), 32'd1);
        chk("rst_mid_ready", 32'(recTREADY), 32'd0);
        cycles(1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_data", 32'(dataStrobe), 32'd0);
        chk("rst_mid_no_index", 32'(indexStrobe), 32'd0);
        chk("rst_mid_gpio", gpioOut, 32'd0);
        chk("rst_mid_outstanding", 32'(outstanding), 32'd0);
        chk("rst_mid_count", 32'(recordCount), 32'd0);
        chk("rst_mid_underflow", 32'(underflow), 32'd0);
        cycles(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
